// File: rtl/program_write_port_pkg.sv
// Shared definitions for the program write port.
// Holds the screen geometry, the transparent colour constant, the SRAM
// arbiter state enum, entry widths and the shift-add pixel address helper.
package program_write_port_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam logic [15:0] TRANSPARENT_COLOR = 16'h07E0;

   localparam int ADDR_W  = 20;
   localparam int DATA_W  = 16;
   localparam int ENTRY_W = ADDR_W + DATA_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2
   } sram_state_t;

   // Word address of a pixel: y*640 + x, built as (y<<9)+(y<<7)+x so no
   // multiplier is needed.
   function automatic logic [ADDR_W-1:0] pixel_addr(input logic [9:0] x,
                                                     input logic [9:0] y);
      logic [ADDR_W-1:0] yy;
      logic [ADDR_W-1:0] xx;
      yy = {10'd0, y};
      xx = {10'd0, x};
      return (yy << 9) + (yy << 7) + xx;
   endfunction

endpackage

// File: rtl/program_write_port_if.sv
// Drawing-engine pixel write channel.
// A pixel {program_x, program_y, program_data} is offered on every cycle
// program_write is high; it is accepted on that cycle when program_ready is
// high (program_ready depends only on registered state, never on
// program_write). A write offered while program_ready is low is lost.
// master: drawing engine (drives coordinates, data, strobe)
// slave : write port (drives program_ready)
interface program_write_port_if;
   logic [9:0]  program_x;
   logic [9:0]  program_y;
   logic [15:0] program_data;
   logic        program_write;
   logic        program_ready;

   modport master (
      output program_x, program_y, program_data, program_write,
      input  program_ready
   );

   modport slave (
      input  program_x, program_y, program_data, program_write,
      output program_ready
   );
endinterface

// File: rtl/program_write_port_sync_fifo.sv
// sync_fifo: single-clock FIFO with a registered occupancy count.
// Ports: clk, reset (sync, active-high), push/push_data, pop, head (current
// front entry, valid when count != 0), count (0..Depth).
// A push while full and a pop while empty are ignored. Depth must be a
// power of two so the pointers wrap naturally.
module sync_fifo #(
   parameter int Width = 36,
   parameter int Depth = 16,
   localparam int PtrW   = $clog2(Depth),
   localparam int CountW = PtrW + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [Width-1:0]  push_data,
   input  logic              pop,
   output logic [Width-1:0]  head,
   output logic [CountW-1:0] count
);

   logic [Width-1:0] mem [Depth];
   logic [PtrW-1:0]  wr_ptr;
   logic [PtrW-1:0]  rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && (count != CountW'(Depth));
   assign do_pop  = pop && (count != '0);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CountW'(1);
            2'b01:   count <= count - CountW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: an entry is only read after it was written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/program_write_port.sv
// program_write_port: buffers drawing-engine pixel writes in a FIFO and
// drains them into an asynchronous SRAM, sharing the SRAM with display
// reads that always win.
// Ports:
//   clk, reset               system clock, sync active-high reset
//   prog (slave)             pixel write channel (x, y, data, write, ready)
//   overflow/overflow_clear  sticky "write lost because FIFO full" flag
//   idle                     FIFO empty and no SRAM write in flight
//   vga_read_req/addr        display read request (one word per cycle)
//   vga_read_data/valid      read return, two cycles after the request
//   sram_*                   registered SRAM pins
//   state_dbg                current arbiter state
module program_write_port
   import program_write_port_pkg::*;
#(
   parameter int FifoDepth = 16,
   parameter int ScreenW   = SCREEN_W,
   parameter int ScreenH   = SCREEN_H
) (
   input  logic                clk,
   input  logic                reset,
   program_write_port_if.slave prog,
   output logic                overflow,
   input  logic                overflow_clear,
   output logic                idle,
   input  logic                vga_read_req,
   input  logic [ADDR_W-1:0]   vga_read_addr,
   output logic [DATA_W-1:0]   vga_read_data,
   output logic                vga_read_valid,
   output logic [ADDR_W-1:0]   sram_addr,
   output logic [DATA_W-1:0]   sram_dq_out,
   output logic                sram_dq_oe,
   input  logic [DATA_W-1:0]   sram_dq_in,
   output logic                sram_we_n,
   output logic                sram_oe_n,
   output sram_state_t         state_dbg
);

   localparam int CountW = $clog2(FifoDepth) + 1;

   logic [CountW-1:0]  fifo_count;
   logic [ENTRY_W-1:0] fifo_head;
   logic [ENTRY_W-1:0] push_entry;
   logic               in_range;
   logic               write_ok;
   logic               fifo_full;
   logic               push;
   logic               pop;
   sram_state_t        state;
   sram_state_t        next_state;

   // ------------------------------------------------------------------
   // Accept side
   // ------------------------------------------------------------------
   assign in_range = ({22'd0, prog.program_x} < ScreenW) &&
                     ({22'd0, prog.program_y} < ScreenH);
   assign write_ok = prog.program_write && in_range;
   // Full is taken from the registered count, so a pop in the same cycle
   // does not make room for a push until the next cycle.
   assign fifo_full          = (fifo_count == CountW'(FifoDepth));
   assign prog.program_ready = !fifo_full;
   assign push               = write_ok && !fifo_full;
   assign push_entry         = {pixel_addr(prog.program_x, prog.program_y),
                                prog.program_data};

   sync_fifo #(
      .Width (ENTRY_W),
      .Depth (FifoDepth)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (fifo_head),
      .count     (fifo_count)
   );

   // Out-of-range writes never reach this test, so they cannot set the flag.
   // Setting takes priority over a simultaneous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (write_ok && fifo_full) begin
         overflow <= 1'b1;
      end else if (overflow_clear) begin
         overflow <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // SRAM arbiter: the state names what the registered SRAM pins are doing
   // in the current cycle. The head entry is popped on the cycle the WRITE
   // decision is made, so it is registered onto the pins as WRITE begins.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = IDLE;
      pop        = 1'b0;
      if (vga_read_req) begin
         next_state = READ;
      end else if (fifo_count != '0) begin
         next_state = WRITE;
         pop        = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_we_n   <= 1'b1;
         sram_oe_n   <= 1'b1;
      end else begin
         case (next_state)
            READ: begin
               sram_addr  <= vga_read_addr;
               sram_we_n  <= 1'b1;
               sram_oe_n  <= 1'b0;
               sram_dq_oe <= 1'b0;
            end
            WRITE: begin
               sram_addr   <= fifo_head[ENTRY_W-1:DATA_W];
               sram_dq_out <= fifo_head[DATA_W-1:0];
               sram_we_n   <= 1'b0;
               sram_oe_n   <= 1'b1;
               sram_dq_oe  <= 1'b1;
            end
            default: begin
               // sram_addr and sram_dq_out keep their last values.
               sram_we_n  <= 1'b1;
               sram_oe_n  <= 1'b1;
               sram_dq_oe <= 1'b0;
            end
         endcase
      end
   end

   // Read data is captured at the end of the READ cycle, giving a
   // request-to-valid latency of two cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         vga_read_valid <= 1'b0;
         vga_read_data  <= '0;
      end else begin
         vga_read_valid <= (state == READ);
         if (state == READ) vga_read_data <= sram_dq_in;
      end
   end

   assign idle      = (fifo_count == '0) && (state != WRITE);
   assign state_dbg = state;

endmodule

// File: tb/tb_program_write_port.sv
// Self-checking bench for program_write_port: directed scenarios plus a
// randomized phase, all compared against a cycle-level reference model of
// the documented behaviour (occupancy queue, overflow flag, read pipeline).
module tb_program_write_port;
   import program_write_port_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        overflow;
   logic        overflow_clear;
   logic        idle;
   logic        vga_read_req;
   logic [19:0] vga_read_addr;
   logic [15:0] vga_read_data;
   logic        vga_read_valid;
   logic [19:0] sram_addr;
   logic [15:0] sram_dq_out;
   logic        sram_dq_oe;
   logic [15:0] sram_dq_in;
   logic        sram_we_n;
   logic        sram_oe_n;
   sram_state_t state_dbg;
   logic [15:0] dq_key;

   program_write_port_if prog_if ();

   program_write_port dut (
      .clk            (clk),
      .reset          (reset),
      .prog           (prog_if),
      .overflow       (overflow),
      .overflow_clear (overflow_clear),
      .idle           (idle),
      .vga_read_req   (vga_read_req),
      .vga_read_addr  (vga_read_addr),
      .vga_read_data  (vga_read_data),
      .vga_read_valid (vga_read_valid),
      .sram_addr      (sram_addr),
      .sram_dq_out    (sram_dq_out),
      .sram_dq_oe     (sram_dq_oe),
      .sram_dq_in     (sram_dq_in),
      .sram_we_n      (sram_we_n),
      .sram_oe_n      (sram_oe_n),
      .state_dbg      (state_dbg)
   );

   // SRAM model: asynchronous read data is a keyed function of the address.
   assign sram_dq_in = sram_oe_n ? 16'h0000 : (sram_addr[15:0] ^ dq_key);

   // ---------------- clock / reset ----------------
   always #10 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   // ---------------- checking ----------------
   int checks   = 0;
   int failures = 0;

   task automatic check_value(input string tag, input logic [35:0] got,
                              input logic [35:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
      end
   endtask

   // ---------------- reference model + scoreboard ----------------
   logic [35:0] exp_q[$];     // pending writes, acceptance order
   bit          chk_en = 1'b0;
   bit          rd_now, val_now, wr_now, ovf_m;
   logic [19:0] rd_addr_m, last_addr_m;
   logic [15:0] val_data_m;
   logic [35:0] wr_entry_m;
   int          wr_count = 0;

   always @(negedge clk) begin
      int          occ;
      int          lin;
      bit          in_range, do_push, do_pop;
      logic [35:0] entry;
      logic [35:0] popped;
      if (chk_en) begin
         check_value("ready", prog_if.program_ready, exp_q.size() != 16);
         check_value("overflow", overflow, ovf_m);
         check_value("we_n", sram_we_n, !wr_now);
         check_value("oe_n", sram_oe_n, !rd_now);
         check_value("dq_oe", sram_dq_oe, wr_now);
         check_value("sram_addr", sram_addr, last_addr_m);
         if (wr_now) check_value("wr_data", sram_dq_out, wr_entry_m[15:0]);
         check_value("rd_valid", vga_read_valid, val_now);
         if (val_now) check_value("rd_data", vga_read_data, val_data_m);
         check_value("idle", idle, (exp_q.size() == 0) && !wr_now);
         if (sram_we_n == 1'b0) wr_count++;
      end
      if (reset) begin
         exp_q.delete();
         rd_now = 0; val_now = 0; wr_now = 0; ovf_m = 0;
         last_addr_m = '0; val_data_m = '0; rd_addr_m = '0;
         chk_en = 1'b1;
      end else if (chk_en) begin
         occ      = exp_q.size();
         in_range = (int'(prog_if.program_x) < 640) && (int'(prog_if.program_y) < 480);
         lin      = int'(prog_if.program_y) * 640 + int'(prog_if.program_x);
         entry    = {lin[19:0], prog_if.program_data};
         do_push  = prog_if.program_write && in_range && (occ < 16);
         do_pop   = !vga_read_req && (occ > 0);
         if (prog_if.program_write && in_range && occ == 16) ovf_m = 1'b1;
         else if (overflow_clear) ovf_m = 1'b0;
         val_now = rd_now;
         if (rd_now) val_data_m = rd_addr_m[15:0] ^ dq_key;
         rd_now = vga_read_req;
         if (vga_read_req) begin
            rd_addr_m   = vga_read_addr;
            last_addr_m = vga_read_addr;
         end
         wr_now = do_pop;
         if (do_pop) begin
            popped      = exp_q.pop_front();
            wr_entry_m  = popped;
            last_addr_m = popped[35:16];
         end
         if (do_push) exp_q.push_back(entry);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of inputs, then return strobes to their quiet values.
   task automatic drive(input bit w, input logic [9:0] x, input logic [9:0] y,
                        input logic [15:0] d, input bit rq,
                        input logic [19:0] ra, input bit oc);
      prog_if.program_write = w;
      prog_if.program_x     = x;
      prog_if.program_y     = y;
      prog_if.program_data  = d;
      vga_read_req          = rq;
      vga_read_addr         = ra;
      overflow_clear        = oc;
      step();
      prog_if.program_write = 1'b0;
      vga_read_req          = 1'b0;
      overflow_clear        = 1'b0;
   endtask

   task automatic quiet(input int n);
      repeat (n) drive(0, 10'd0, 10'd0, 16'h0, 0, 20'h0, 0);
   endtask

   task automatic write_under_read(input int n);
      for (int i = 0; i < n; i++)
         drive(1, 10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)),
               16'($urandom), 1, 20'($urandom), 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int  base;
      bit  found;
      reset                 = 1'b1;
      dq_key                = 16'h5A5A;
      prog_if.program_write = 1'b0;
      prog_if.program_x     = '0;
      prog_if.program_y     = '0;
      prog_if.program_data  = '0;
      vga_read_req          = 1'b0;
      vga_read_addr         = '0;
      overflow_clear        = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state
      @(negedge clk);
      check_value("rst_idle", idle, 1);
      check_value("rst_ready", prog_if.program_ready, 1);
      check_value("rst_we_n", sram_we_n, 1);
      check_value("rst_oe_n", sram_oe_n, 1);
      check_value("rst_addr", sram_addr, 0);
      check_value("rst_ovf", overflow, 0);
      check_value("rst_state", 36'(state_dbg), 36'(IDLE));
      step();

      // Single write (3,2) -> addr 1283 within 2 cycles
      drive(1, 10'd3, 10'd2, 16'hF800, 0, 20'h0, 0);
      found = 1'b0;
      for (int i = 0; i < 3 && !found; i++) begin
         @(negedge clk);
         if (sram_we_n == 1'b0) begin
            found = 1'b1;
            check_value("w1_addr", sram_addr, 36'd1283);
            check_value("w1_data", sram_dq_out, 36'hF800);
         end
         step();
      end
      check_value("w1_seen", found, 1);
      @(negedge clk);
      check_value("w1_idle", idle, 1);
      step();

      // Corner pixel, then an out-of-range x
      drive(1, 10'd639, 10'd479, 16'h1234, 0, 20'h0, 0);
      step();
      @(negedge clk);
      check_value("corner_addr", sram_addr, 36'd307199);
      step();
      base = wr_count;
      drive(1, 10'd640, 10'd0, 16'h4321, 0, 20'h0, 0);
      quiet(3);
      check_value("oor_no_write", wr_count - base, 0);
      check_value("oor_ovf", overflow, 0);

      // Single read with known return data
      dq_key = 16'h2345 ^ 16'hABCD;
      drive(0, 10'd0, 10'd0, 16'h0, 1, 20'h12345, 0);
      @(negedge clk);
      check_value("rd_addr", sram_addr, 36'h12345);
      check_value("rd_oe_n", sram_oe_n, 0);
      step();
      @(negedge clk);
      check_value("rd_valid1", vga_read_valid, 1);
      check_value("rd_data1", vga_read_data, 36'hABCD);
      step();
      dq_key = 16'h5A5A;

      // 20 reads with 20 writes: 16 accepted, overflow, ordered drain
      for (int i = 0; i < 20; i++)
         drive(1, 10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)),
               16'($urandom), 1, 20'($urandom), 0);
      base = wr_count;
      @(negedge clk);
      check_value("burst_ovf", overflow, 1);
      check_value("burst_ready", prog_if.program_ready, 0);
      step();
      quiet(30);
      check_value("burst_drain", wr_count - base, 16);
      drive(0, 10'd0, 10'd0, 16'h0, 0, 20'h0, 1);
      @(negedge clk);
      check_value("burst_clr", overflow, 0);
      step();

      // Full FIFO: push and pop in the same cycle
      write_under_read(16);
      drive(1, 10'd5, 10'd5, 16'hBEEF, 0, 20'h0, 0);
      @(negedge clk);
      check_value("pp_ovf", overflow, 1);
      check_value("pp_ready", prog_if.program_ready, 1);
      step();
      drive(0, 10'd0, 10'd0, 16'h0, 0, 20'h0, 1);
      @(negedge clk);
      check_value("pp_clr", overflow, 0);
      step();
      quiet(20);

      // Reset with 8 writes pending
      write_under_read(8);
      reset = 1'b1;
      step();
      reset = 1'b0;
      base  = wr_count;
      @(negedge clk);
      check_value("mid_rst_we_n", sram_we_n, 1);
      check_value("mid_rst_idle", idle, 1);
      check_value("mid_rst_ready", prog_if.program_ready, 1);
      step();
      quiet(10);
      check_value("mid_rst_nowr", wr_count - base, 0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) dq_key = 16'($urandom);
         drive(1'($urandom_range(0, 1)), 10'($urandom_range(0, 700)),
               10'($urandom_range(0, 520)), 16'($urandom),
               ($urandom_range(0, 2) == 0), 20'($urandom),
               ($urandom_range(0, 19) == 0));
      end
      quiet(40);
      check_value("final_empty", exp_q.size(), 0);
      @(negedge clk);
      check_value("final_idle", idle, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/program_write_port.md
PROGRAM_WRITE_PORT -- requirements
Module: program_write_port

Interface
REQ-001 Parameter FifoDepth, default 16, meaning: pending-write FIFO entries (power of two).
REQ-002 Parameter ScreenW, default 640, meaning: pixels per line for address computation.
REQ-003 Parameter ScreenH, default 480, meaning: visible lines; writes at or beyond this are discarded.
REQ-004 clk  in  1  system clock, 50 MHz.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 program_x, program_y  in  10 each  destination pixel coordinate from the drawing engine.
REQ-007 program_data  in  16  RGB565 pixel value.
REQ-008 program_write  in  1  write strobe, one pixel per asserted cycle.
REQ-009 program_ready  out  1  high when the FIFO can accept a write this cycle.
REQ-010 overflow  out  1  sticky flag: a write arrived while full.
REQ-011 overflow_clear  in  1  clears overflow.
REQ-012 idle  out  1  FIFO empty and no SRAM write in flight.
REQ-013 vga_read_req  in  1  display read request; vga_read_addr  in  20  word address.
REQ-014 vga_read_data  out  16  and vga_read_valid  out  1  read return.
REQ-015 sram_addr  out  20; sram_dq_out  out  16; sram_dq_oe  out  1; sram_dq_in  in  16; sram_we_n, sram_oe_n  out  1 each.

Function
REQ-016 Accept: on program_write with program_x<ScreenW and program_y<ScreenH and FIFO not full, push {addr, data} in the same cycle.
REQ-017 Address: addr = program_y*640 + program_x, computed as (y<<9)+(y<<7)+x, 20-bit, no multiplier.
REQ-018 Out-of-range coordinates are silently dropped; they never set overflow.
REQ-019 program_ready = (count != FifoDepth), combinational from registered count.
REQ-020 Write while full: data dropped, overflow set next cycle; overflow stays set until overflow_clear or reset; set wins over simultaneous clear.
REQ-021 Push and pop in the same cycle are allowed, including when full (pop frees the slot only next cycle; push while full is still dropped) and when empty (no bypass; push lands, pop does not occur).
REQ-022 State machine states IDLE, READ, WRITE, evaluated every cycle; next state: READ if vga_read_req, else WRITE if FIFO non-empty, else IDLE.
REQ-023 Display reads have strict priority; writes use only cycles with no read request.
REQ-024 READ cycle: sram_addr = captured vga_read_addr, sram_oe_n=0, sram_we_n=1, sram_dq_oe=0.
REQ-025 WRITE cycle: pop FIFO head; sram_addr/sram_dq_out = entry, sram_we_n=0, sram_oe_n=1, sram_dq_oe=1.
REQ-026 IDLE: sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, sram_addr holds last value.
REQ-027 All SRAM outputs registered; read latency: vga_read_req in cycle N -> READ in N+1 -> vga_read_valid with registered sram_dq_in in N+2, one-cycle pulse.
REQ-028 Back-to-back read requests every cycle are honoured with 1-per-cycle throughput and zero writes.
REQ-029 FIFO order preserved: SRAM writes occur in program_write acceptance order.
REQ-030 idle = (count==0) and state!=WRITE.

Reset
REQ-031 Reset: state IDLE, FIFO count/pointers 0, overflow 0, vga_read_valid 0, sram_we_n 1, sram_oe_n 1, sram_dq_oe 0, sram_addr 0, vga_read_data 0.
REQ-032 Reset mid-operation discards all pending FIFO entries; no write strobe in the cycle after reset asserts.

Structure
REQ-033 Shared package holds SCREEN_W/SCREEN_H constants, the TRANSPARENT_COLOR constant 16'h07E0, and the sram_state_t enum.
REQ-034 One sub-module, sync_fifo (parameterised width/depth, count output), instantiated with 36-bit entries.

Verification
REQ-035 Write (x=3,y=2,data=16'hF800), no reads -> exactly one WRITE cycle with sram_addr=1283, sram_dq_out=16'hF800, we_n low, within 2 cycles; idle returns high.
REQ-036 Write (x=639,y=479) -> sram_addr=307199; write (x=640,y=0) -> no push, overflow stays 0.
REQ-037 vga_read_req held 20 cycles while 20 writes pushed -> program_ready low after 16th, overflow set, reads return sram_dq_in 2 cycles after each request, 16 writes drain in order after req drops.
REQ-038 Read request at cycle N with addr 20'h12345 and model returning 16'hABCD -> sram_addr=20'h12345, oe_n low at N+1, vga_read_valid with 16'hABCD at N+2.
REQ-039 Full FIFO, simultaneous push and pop -> pushed data dropped, overflow=1, count 15 next cycle; overflow_clear -> overflow 0.
REQ-040 Reset asserted with 8 entries pending -> no further we_n pulses, idle=1, program_ready=1 next cycle.
